graphics_compositor: RTL and testbench

Parametrised, pipelined successor to the single-cycle combinational compositor. It performs four jobs:
- Maps raster counters (hc, vc) to rotated playfield coordinates.
- Issues maze-RAM addresses.
- Aligns N sprite colour channels with the RAM read latency, then priority-mixes them over the maze into a registered pixel colour.
- Reports per-frame sprite-vs-player collisions.

It sits between the VGA timing generator, the sprite renderers (fed from xpos/ypos), the maze ping-pong RAM and the VGA output.

---
 rtl/graphics_pkg.sv | 29 ++
 rtl/graphics_delay_line.sv | 44 ++++
 rtl/graphics_compositor.sv | 166 ++++++++++++++++
 tb/tb_graphics_compositor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// Shared constants for the graphics compositor: RGB332 palette, raster
// limits and default rotated-playfield geometry.
package graphics_pkg;

    // RGB332 palette (RRR_GGG_BB)
    localparam logic [7:0] RED = 8'hE0;
    localparam logic [7:0] PNK = 8'hF3;
    localparam logic [7:0] CYN = 8'h1F;
    localparam logic [7:0] ORG = 8'hF4;
    localparam logic [7:0] YLW = 8'hFC;
    localparam logic [7:0] WHT = 8'hFF;
    localparam logic [7:0] CRM = 8'hFE;
    localparam logic [7:0] BLU = 8'h03;
    localparam logic [7:0] BLK = 8'h00;

    // Visible raster area of the VGA timing generator
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    // Default rotated playfield geometry
    localparam int DEF_XMAX       = 240;
    localparam int DEF_YMAX       = 320;
    localparam int DEF_ROW_STRIDE = 264;
    localparam int DEF_YOFFSET    = 24;

    // Rotated playfield coordinate
    typedef logic [8:0] coord_t;

endpackage

// File: rtl/graphics_delay_line.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a plain wire.
module graphics_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_d [DEPTH];
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Next state of each stage: shift one position towards the output
            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Stage registers, cleared by the asynchronous active-low reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/graphics_compositor.sv
// Pipelined compositor: raster-to-playfield rotation, maze RAM addressing,
// sprite/maze priority mix aligned to RAM latency, and per-frame
// sprite-versus-player collision reporting.
module graphics_compositor
    import graphics_pkg::*;
#(
    parameter int                 NUM_SPRITES = 5,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 8'h00,
    parameter int                 XMAX        = DEF_XMAX,
    parameter int                 YMAX        = DEF_YMAX,
    parameter int                 ROW_STRIDE  = DEF_ROW_STRIDE,
    parameter int                 YOFFSET     = DEF_YOFFSET,
    parameter int                 ADDR_W      = 16,
    parameter int                 RAM_LATENCY = 1,
    parameter int                 PLAYER_IDX  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     hc,
    input  logic [9:0]                     vc,
    input  logic [NUM_SPRITES-1:0]         chan_en,
    output logic [8:0]                     xpos,
    output logic [8:0]                     ypos,
    output logic                           pix_valid,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
    output logic [ADDR_W-1:0]              address,
    input  logic [COLOR_W-1:0]             maze_color,
    output logic [COLOR_W-1:0]             color,
    output logic [NUM_SPRITES-1:0]         collide_mask,
    output logic                           collide_valid
);

    localparam int BUS_W = NUM_SPRITES*COLOR_W + 3;

    // Stage S1 state
    coord_t              xpos_d, xpos_q;
    coord_t              ypos_d, ypos_q;
    logic                pix_valid_d, pix_valid_q;
    logic                sof_d, sof_q;
    logic                eof_d, eof_q;
    logic [ADDR_W-1:0]   address_d, address_q;
    logic                visible_s;
    logic                in_window_s;

    // Alignment outputs
    logic [BUS_W-1:0]               dly_in_s, dly_out_s;
    logic [NUM_SPRITES*COLOR_W-1:0] spr_dly_s;
    logic                           valid_dly_s, sof_dly_s, eof_dly_s;

    // Mix / collision state
    logic [NUM_SPRITES-1:0] en_d, en_q;
    logic [NUM_SPRITES-1:0] sticky_d, sticky_q;
    logic [NUM_SPRITES-1:0] collide_mask_d, collide_mask_q;
    logic                   collide_valid_d, collide_valid_q;
    logic [COLOR_W-1:0]     color_d, color_q;
    logic [NUM_SPRITES-1:0] opaque_s, player_mask_s, hit_s, sticky_acc_s;
    logic [COLOR_W-1:0]     mix_s;

    // S1: rotate raster counters, flag frame boundaries, form RAM address
    always_comb begin
        visible_s   = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
        sof_d       = (hc == 10'd0) && (vc == 10'd0);
        eof_d       = (hc == 10'(H_VISIBLE-1)) && (vc == 10'(V_VISIBLE-1));
        pix_valid_d = visible_s;
        if (visible_s) begin
            xpos_d = 9'(XMAX-1) - vc[9:1];
            ypos_d = hc[9:1];
        end else begin
            xpos_d = 9'd0;
            ypos_d = 9'd0;
        end
        in_window_s = visible_s
                   && ({1'b0, ypos_d} >= 10'(YOFFSET))
                   && ({1'b0, ypos_d} <  10'(YOFFSET + ROW_STRIDE))
                   && ({1'b0, ypos_d} <  10'(YMAX));
        // Product formed at 32 bits so only the final truncation wraps
        if (in_window_s) begin
            address_d = ADDR_W'(32'(xpos_d) * 32'(ROW_STRIDE) + 32'(ypos_d) - 32'(YOFFSET));
        end else begin
            address_d = {ADDR_W{1'b1}};
        end
    end

    assign dly_in_s = {sprite_color, pix_valid_q, sof_q, eof_q};

    graphics_delay_line #(
        .WIDTH (BUS_W),
        .DEPTH (RAM_LATENCY)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  (dly_in_s),
        .dout (dly_out_s)
    );

    assign {spr_dly_s, valid_dly_s, sof_dly_s, eof_dly_s} = dly_out_s;

    // Priority mix, frame-boundary enable latch and sticky collision update
    always_comb begin
        player_mask_s = NUM_SPRITES'(1) << PLAYER_IDX;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque_s[i] = en_q[i] && (spr_dly_s[i*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
        mix_s = (maze_color != TRANSPARENT) ? maze_color : TRANSPARENT;
        // Walk from lowest priority up so channel 0 wins last
        for (int i = NUM_SPRITES-1; i >= 0; i--) begin
            mix_s = opaque_s[i] ? spr_dly_s[i*COLOR_W +: COLOR_W] : mix_s;
        end
        color_d = valid_dly_s ? mix_s : {COLOR_W{1'b0}};
        en_d    = sof_dly_s ? chan_en : en_q;
        if (valid_dly_s && ((opaque_s & player_mask_s) != {NUM_SPRITES{1'b0}})) begin
            hit_s = opaque_s & ~player_mask_s;
        end else begin
            hit_s = {NUM_SPRITES{1'b0}};
        end
        sticky_acc_s = sticky_q | hit_s;
        if (eof_dly_s) begin
            collide_mask_d  = sticky_acc_s;
            collide_valid_d = 1'b1;
            sticky_d        = {NUM_SPRITES{1'b0}};
        end else begin
            collide_mask_d  = collide_mask_q;
            collide_valid_d = 1'b0;
            sticky_d        = sticky_acc_s;
        end
    end

    // All pipeline and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xpos_q          <= 9'd0;
            ypos_q          <= 9'd0;
            pix_valid_q     <= 1'b0;
            sof_q           <= 1'b0;
            eof_q           <= 1'b0;
            address_q       <= {ADDR_W{1'b1}};
            en_q            <= {NUM_SPRITES{1'b1}};
            sticky_q        <= {NUM_SPRITES{1'b0}};
            collide_mask_q  <= {NUM_SPRITES{1'b0}};
            collide_valid_q <= 1'b0;
            color_q         <= {COLOR_W{1'b0}};
        end else begin
            xpos_q          <= xpos_d;
            ypos_q          <= ypos_d;
            pix_valid_q     <= pix_valid_d;
            sof_q           <= sof_d;
            eof_q           <= eof_d;
            address_q       <= address_d;
            en_q            <= en_d;
            sticky_q        <= sticky_d;
            collide_mask_q  <= collide_mask_d;
            collide_valid_q <= collide_valid_d;
            color_q         <= color_d;
        end
    end

    assign xpos          = xpos_q;
    assign ypos          = ypos_q;
    assign pix_valid     = pix_valid_q;
    assign address       = address_q;
    assign color         = color_q;
    assign collide_mask  = collide_mask_q;
    assign collide_valid = collide_valid_q;

endmodule

// File: tb/tb_graphics_compositor.sv
// Directed bench for graphics_compositor with default parameters.
module tb_graphics_compositor;
    import graphics_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  hc, vc;
    logic [4:0]  chan_en;
    logic [8:0]  xpos, ypos;
    logic        pix_valid;
    logic [39:0] sprite_color;
    logic [15:0] address;
    logic [7:0]  maze_val;
    logic [7:0]  color;
    logic [4:0]  collide_mask;
    logic        collide_valid;

    int tests = 0;
    int fails = 0;

    // Sprite renderer model: each channel shows its colour at one playfield
    // point, or everywhere when ch_any is set
    logic [7:0] ch_col [5];
    logic [8:0] ch_x   [5];
    logic [8:0] ch_y   [5];
    logic       ch_any [5];

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            sprite_color[i*8 +: 8] = (ch_any[i] || (xpos == ch_x[i] && ypos == ch_y[i])) ? ch_col[i] : 8'h00;
        end
    end

    graphics_compositor dut (
        .clk           (clk),
        .rst           (rst),
        .hc            (hc),
        .vc            (vc),
        .chan_en       (chan_en),
        .xpos          (xpos),
        .ypos          (ypos),
        .pix_valid     (pix_valid),
        .sprite_color  (sprite_color),
        .address       (address),
        .maze_color    (maze_val),
        .color         (color),
        .collide_mask  (collide_mask),
        .collide_valid (collide_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [9:0] h, input logic [9:0] v);
        @(posedge clk);
        #1;
        hc = h;
        vc = v;
    endtask

    // Apply h/v and wait until its S1 outputs are visible
    task automatic step(input logic [9:0] h, input logic [9:0] v);
        drive(h, v);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if (xpos !== 9'd0) begin fails++; $display("FAIL rst_xpos: got %0d exp 0", xpos); end
        tests++; if (ypos !== 9'd0) begin fails++; $display("FAIL rst_ypos: got %0d exp 0", ypos); end
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", pix_valid); end
        tests++; if (address !== 16'hFFFF) begin fails++; $display("FAIL rst_addr: got %h exp ffff", address); end
        tests++; if (color !== 8'h00) begin fails++; $display("FAIL rst_color: got %h exp 00", color); end
        tests++; if (collide_mask !== 5'd0) begin fails++; $display("FAIL rst_mask: got %b exp 00000", collide_mask); end
        tests++; if (collide_valid !== 1'b0) begin fails++; $display("FAIL rst_cvalid: got %b exp 0", collide_valid); end
        rst = 1'b1;
    endtask

    task automatic test_latency;
        ch_col[0] = RED; ch_x[0] = 9'd214; ch_y[0] = 9'd50;
        drive(10'd100, 10'd50);
        drive(10'd700, 10'd0);
        @(negedge clk);
        tests++; if (xpos !== 9'd214) begin fails++; $display("FAIL lat_xpos: got %0d exp 214", xpos); end
        tests++; if (ypos !== 9'd50) begin fails++; $display("FAIL lat_ypos: got %0d exp 50", ypos); end
        tests++; if (pix_valid !== 1'b1) begin fails++; $display("FAIL lat_valid: got %b exp 1", pix_valid); end
        tests++; if (address !== 16'd56522) begin fails++; $display("FAIL lat_addr: got %0d exp 56522", address); end
        @(negedge clk);
        tests++; if (color !== 8'h00) begin fails++; $display("FAIL lat_early: got %h exp 00", color); end
        @(negedge clk);
        tests++; if (color !== RED) begin fails++; $display("FAIL lat_color: got %h exp %h", color, RED); end
        @(negedge clk);
        tests++; if (color !== 8'h00) begin fails++; $display("FAIL lat_after: got %h exp 00", color); end
        ch_col[0] = 8'h00;
    endtask

    task automatic test_priority;
        for (int i = 0; i < 5; i++) begin ch_any[i] = 1'b1; ch_col[i] = 8'h00; end
        ch_col[1] = PNK; ch_col[3] = CYN; maze_val = BLU;
        drive(10'd100, 10'd50);
        repeat (4) @(negedge clk);
        tests++; if (color !== PNK) begin fails++; $display("FAIL prio_pnk: got %h exp %h", color, PNK); end
        ch_col[1] = 8'h00;
        repeat (4) @(negedge clk);
        tests++; if (color !== CYN) begin fails++; $display("FAIL prio_cyn: got %h exp %h", color, CYN); end
        ch_col[3] = 8'h00;
        repeat (4) @(negedge clk);
        tests++; if (color !== BLU) begin fails++; $display("FAIL prio_maze: got %h exp %h", color, BLU); end
        maze_val = 8'h00;
        repeat (4) @(negedge clk);
        tests++; if (color !== 8'h00) begin fails++; $display("FAIL prio_none: got %h exp 00", color); end
    endtask

    task automatic test_enable;
        ch_col[1] = PNK; ch_col[3] = CYN; maze_val = BLU;
        chan_en = 5'b11101;
        repeat (4) @(negedge clk);
        tests++; if (color !== PNK) begin fails++; $display("FAIL en_midframe: got %h exp %h", color, PNK); end
        drive(10'd0, 10'd0);
        drive(10'd100, 10'd50);
        repeat (5) @(negedge clk);
        tests++; if (color !== CYN) begin fails++; $display("FAIL en_suppress: got %h exp %h", color, CYN); end
        chan_en = 5'b11111;
        drive(10'd0, 10'd0);
        drive(10'd100, 10'd50);
        repeat (5) @(negedge clk);
        tests++; if (color !== PNK) begin fails++; $display("FAIL en_restore: got %h exp %h", color, PNK); end
    endtask

    task automatic test_address_window;
        step(10'd46, 10'd0);
        tests++; if (address !== 16'hFFFF) begin fails++; $display("FAIL addr_y23: got %h exp ffff", address); end
        tests++; if (pix_valid !== 1'b1) begin fails++; $display("FAIL addr_y23_valid: got %b exp 1", pix_valid); end
        step(10'd576, 10'd0);
        tests++; if (address !== 16'hFFFF) begin fails++; $display("FAIL addr_y288: got %h exp ffff", address); end
        step(10'd48, 10'd478);
        tests++; if (address !== 16'h0000) begin fails++; $display("FAIL addr_origin: got %h exp 0000", address); end
        tests++; if (xpos !== 9'd0) begin fails++; $display("FAIL addr_origin_x: got %0d exp 0", xpos); end
        step(10'd574, 10'd0);
        tests++; if (address !== 16'hF77F) begin fails++; $display("FAIL addr_y287: got %h exp f77f", address); end
        step(10'd100, 10'd480);
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL addr_vc480: got %b exp 0", pix_valid); end
        step(10'd700, 10'd0);
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL addr_hc700_valid: got %b exp 0", pix_valid); end
        tests++; if (address !== 16'hFFFF) begin fails++; $display("FAIL addr_hc700: got %h exp ffff", address); end
        repeat (2) @(negedge clk);
        tests++; if (color !== 8'h00) begin fails++; $display("FAIL addr_hc700_color: got %h exp 00", color); end
    endtask

    task automatic test_collision;
        int         pulses;
        logic [4:0] seen;
        logic [4:0] exp_mask [3];
        exp_mask[0] = 5'b00100; exp_mask[1] = 5'b00000; exp_mask[2] = 5'b00000;
        for (int i = 0; i < 5; i++) begin ch_any[i] = 1'b0; ch_col[i] = 8'h00; end
        maze_val = 8'h00;
        ch_col[4] = WHT; ch_x[4] = 9'd214; ch_y[4] = 9'd50;
        ch_x[2] = 9'd214; ch_y[2] = 9'd50;
        ch_col[1] = PNK; ch_x[1] = 9'd200; ch_y[1] = 9'd60;
        // Frame 0: overlap with ch2; frame 1: player alone; frame 2: ch2 disabled
        for (int f = 0; f < 3; f++) begin
            ch_col[2] = (f == 1) ? 8'h00 : ORG;
            chan_en   = (f == 2) ? 5'b11011 : 5'b11111;
            drive(10'd0, 10'd0);
            drive(10'd100, 10'd50);
            drive(10'd120, 10'd78);
            drive(10'd639, 10'd479);
            drive(10'd700, 10'd0);
            pulses = 0; seen = 5'b11111;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (collide_valid === 1'b1) begin pulses++; seen = collide_mask; end
            end
            tests++; if (pulses != 1) begin fails++; $display("FAIL coll_pulse%0d: got %0d pulses exp 1", f, pulses); end
            tests++; if (seen !== exp_mask[f]) begin fails++; $display("FAIL coll_mask%0d: got %b exp %b", f, seen, exp_mask[f]); end
        end
        chan_en = 5'b11111;
    endtask

    task automatic test_async_reset;
        int early;
        int pulses;
        logic [4:0] seen;
        ch_any[0] = 1'b1; ch_col[0] = RED;
        ch_col[1] = 8'h00; ch_col[2] = 8'h00;
        drive(10'd0, 10'd0);
        drive(10'd100, 10'd50);
        repeat (4) @(negedge clk);
        tests++; if (color !== RED) begin fails++; $display("FAIL ar_before: got %h exp %h", color, RED); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        tests++; if (color !== 8'h00) begin fails++; $display("FAIL ar_color: got %h exp 00", color); end
        tests++; if (address !== 16'hFFFF) begin fails++; $display("FAIL ar_addr: got %h exp ffff", address); end
        tests++; if (xpos !== 9'd0 || ypos !== 9'd0) begin fails++; $display("FAIL ar_pos: got %0d/%0d exp 0/0", xpos, ypos); end
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b exp 0", pix_valid); end
        ch_col[0] = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        early = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (collide_valid === 1'b1) early++;
        end
        tests++; if (early != 0) begin fails++; $display("FAIL ar_early_pulse: got %0d exp 0", early); end
        drive(10'd639, 10'd479);
        drive(10'd700, 10'd0);
        pulses = 0; seen = 5'b11111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (collide_valid === 1'b1) begin pulses++; seen = collide_mask; end
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL ar_pulse: got %0d exp 1", pulses); end
        tests++; if (seen !== 5'b00000) begin fails++; $display("FAIL ar_mask: got %b exp 00000", seen); end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            ch_col[i] = 8'h00; ch_x[i] = 9'd0; ch_y[i] = 9'd0; ch_any[i] = 1'b0;
        end
        rst      = 1'b0;
        hc       = 10'd700;
        vc       = 10'd0;
        chan_en  = 5'b11111;
        maze_val = 8'h00;
        test_reset;
        test_latency;
        test_priority;
        test_enable;
        test_address_window;
        test_collision;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
